// File: rtl/nes_event_pkg.sv
// Shared event-word layout and SNES button indices for the pad event queue.
// Optional build macro used by nes_button_events: NES_BUTTON_EVENTS_DEBOUNCE_EN.
package nes_event_pkg;

    localparam int unsigned EVT_W         = 8;
    localparam int unsigned EVT_PRESS_BIT = 7;
    localparam int unsigned EVT_INDEX_MSB = 3;
    localparam int unsigned EVT_INDEX_LSB = 0;
    localparam int unsigned EVT_INDEX_W   = EVT_INDEX_MSB - EVT_INDEX_LSB + 1;

    // Button indices in SNES serial shift order
    localparam int unsigned BTN_B      = 0;
    localparam int unsigned BTN_Y      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;
    localparam int unsigned BTN_A      = 8;
    localparam int unsigned BTN_X      = 9;
    localparam int unsigned BTN_L      = 10;
    localparam int unsigned BTN_R      = 11;

    typedef struct packed {
        logic                   press;
        logic [2:0]             rsvd;
        logic [EVT_INDEX_W-1:0] index;
    } evt_word_t;

    function automatic evt_word_t make_evt(input logic press, input logic [EVT_INDEX_W-1:0] index);
        evt_word_t w;
        w.press = press;
        w.rsvd  = 3'b000;
        w.index = index;
        return w;
    endfunction

endpackage

// File: rtl/nes_event_fifo.sv
// Synchronous event FIFO; wrap-bit pointers give full/empty, head reads 0 when empty.
module nes_event_fifo
    import nes_event_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  evt_word_t              wr_data,
    output evt_word_t              rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    evt_word_t     mem [DEPTH];
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts the push
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + PW'(push_ok) - PW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/nes_button_events.sv
// Converts pad button-vector changes into a queue of press/release events.
// Build option: define NES_BUTTON_EVENTS_DEBOUNCE_EN to require STABLE_CYCLES of stability.
module nes_button_events
    import nes_event_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned BUTTONS       = 12,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [15:0]                 nes_state,
    input  logic                        evt_pop,
    input  logic                        clr_overflow,
    output logic [7:0]                  evt_data,
    output logic                        evt_valid,
    output logic [$clog2(FIFO_DEPTH):0] evt_count,
    output logic                        overflow,
    output logic                        irq,
    output logic [BUTTONS-1:0]          btn_state
);

    logic [BUTTONS-1:0] sync1;
    logic [BUTTONS-1:0] sync2;
    logic [BUTTONS-1:0] accepted;
    logic [BUTTONS-1:0] diff_c;
    logic [BUTTONS-1:0] lowest_c;
    logic [EVT_INDEX_W-1:0] sel_idx_c;
    logic               sel_val_c;
    logic               found_c;
    logic               push_c;
    logic               drop_c;
    logic               fifo_full;
    logic               fifo_empty;
    evt_word_t          head;
    logic               unused_hi;

    assign unused_hi = ^nes_state;

    // Two-flop synchronizer: the pad reader runs from an unrelated slow clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= nes_state[BUTTONS-1:0];
            sync2 <= sync1;
        end
    end

`ifdef NES_BUTTON_EVENTS_DEBOUNCE_EN
    localparam int unsigned STAB_W   = $clog2(STABLE_CYCLES) + 1;
    localparam int unsigned STAB_MAX = STABLE_CYCLES - 2;

    logic [BUTTONS-1:0] sync2_d;
    logic [STAB_W-1:0]  stab_cnt;

    // Accept sync2 only after it has held unchanged for STABLE_CYCLES cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync2_d  <= '0;
            stab_cnt <= '0;
            accepted <= '0;
        end else begin
            sync2_d <= sync2;
            if (sync2 != sync2_d) begin
                stab_cnt <= '0;
            end else if (stab_cnt < STAB_W'(STAB_MAX)) begin
                stab_cnt <= stab_cnt + STAB_W'(1);
            end
            if ((sync2 == sync2_d) && (stab_cnt == STAB_W'(STAB_MAX))) accepted <= sync2;
        end
    end
`else
    localparam int unsigned unused_stable_cycles = STABLE_CYCLES;
    assign accepted = sync2;
`endif

    // Lowest-index pending change wins; one event per cycle
    always_comb begin
        diff_c    = accepted ^ btn_state;
        lowest_c  = diff_c & (~diff_c + BUTTONS'(1));
        sel_idx_c = '0;
        sel_val_c = 1'b0;
        found_c   = 1'b0;
        for (int i = 0; i < BUTTONS; i++) begin
            if (diff_c[i] && !found_c) begin
                found_c   = 1'b1;
                sel_idx_c = EVT_INDEX_W'(i);
                sel_val_c = accepted[i];
            end
        end
        push_c = found_c && (!fifo_full || evt_pop);
        drop_c = found_c && fifo_full && !evt_pop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_state <= '0;
            irq       <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            btn_state <= btn_state ^ lowest_c;
            irq       <= push_c;
            if (drop_c)            overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    nes_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_c),
        .pop     (evt_pop),
        .wr_data (make_evt(sel_val_c, sel_idx_c)),
        .rd_data (head),
        .count   (evt_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign evt_data  = head;
    assign evt_valid = !fifo_empty;

endmodule
